// File: rtl/noise_blanker2.sv
// ---------------------------------------------------------------------------
// noise_blanker2
//
// Impulse-noise blanker for a complex (I/Q) sample stream. Each input sample
// gets a cheap magnitude estimate, max(|x|,|y|) + min(|x|,|y|)/2, taken on the
// top MW bits of each component. A sample whose magnitude is above `limit`
// opens a blanking window. The window covers the DLY samples before the pulse,
// which is possible because the output is delayed by DLY samples. It also
// covers the pulse itself and the `hang` samples after it. Samples inside the
// window are replaced by zero.
//
// Ports
//   clk        sample clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   dix, diy   input I/Q sample (DW-bit two's complement)
//   iv         input valid, one sample per asserted clock
//   en         blanking enable (0 = pass-through, detection still runs)
//   limit      magnitude threshold (strictly greater-than detects)
//   hang       post-pulse window extension in samples
//   pkrst      synchronous clear of peak and pcnt
//   dox, doy   delayed, possibly blanked output sample
//   ov         output valid, one cycle after each iv
//   bo         blanked flag, aligned with ov
//   peak       largest magnitude since the last clear
//   pcnt       number of blanking windows started (saturating)
//
// Build option
//   NB_PULSECNT_EN  when defined, the pulse counter behind pcnt is built;
//                   otherwise pcnt is constant zero.
// ---------------------------------------------------------------------------
module noise_blanker2 #(
   parameter int DW  = 18,
   parameter int MW  = 12,
   parameter int DLY = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] dix,
   input  logic [DW-1:0] diy,
   input  logic          iv,
   input  logic          en,
   input  logic [MW-1:0] limit,
   input  logic [7:0]    hang,
   input  logic          pkrst,
   output logic [DW-1:0] dox,
   output logic [DW-1:0] doy,
   output logic          ov,
   output logic          bo,
   output logic [MW-1:0] peak,
   output logic [15:0]   pcnt
);

   // The counter must reach DLY + 255 without wrapping.
   localparam int CW = $clog2(DLY + 256);

   // ------------------------------------------------------------------
   // Magnitude estimate and detection
   // ------------------------------------------------------------------
   logic [MW-1:0] tx, ty;
   logic [MW-1:0] ax, ay;
   logic [MW-1:0] mx, mn;
   logic [MW-1:0] mag;
   logic          det;

   assign tx = dix[DW-1:DW-MW];
   assign ty = diy[DW-1:DW-MW];

   // Two's-complement negate. The most negative value maps to 2^(MW-1),
   // which still fits in MW unsigned bits.
   assign ax = tx[MW-1] ? (~tx + {{(MW-1){1'b0}}, 1'b1}) : tx;
   assign ay = ty[MW-1] ? (~ty + {{(MW-1){1'b0}}, 1'b1}) : ty;

   assign mx = (ax >= ay) ? ax : ay;
   assign mn = (ax >= ay) ? ay : ax;

   // Intentionally truncated to MW bits; no saturation.
   assign mag = mx + (mn >> 1);
   assign det = (mag > limit);

   // ------------------------------------------------------------------
   // Delay line: shifts only on iv, so samples never drain on their own
   // ------------------------------------------------------------------
   logic [DW-1:0] dlx_reg [DLY];
   logic [DW-1:0] dly_reg [DLY];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DLY; i++) begin
            dlx_reg[i] <= '0;
            dly_reg[i] <= '0;
         end
      end else if (iv) begin
         dlx_reg[0] <= dix;
         dly_reg[0] <= diy;
         for (int i = 1; i < DLY; i++) begin
            dlx_reg[i] <= dlx_reg[i-1];
            dly_reg[i] <= dly_reg[i-1];
         end
      end
   end

   // ------------------------------------------------------------------
   // Blanking window counter
   // ------------------------------------------------------------------
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          win_open;
   logic          blank;

   // The window state before this sample's update decides blanking.
   // A fresh detection reloads the counter, which retriggers the window.
   assign win_open = (cnt_reg != '0);
   assign blank    = en & (det | win_open);

   always_comb begin
      cnt_next = cnt_reg;
      if (det)
         cnt_next = CW'(DLY) + CW'(hang);
      else if (win_open)
         cnt_next = cnt_reg - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_reg <= '0;
      else if (iv)
         cnt_reg <= cnt_next;
   end

   // ------------------------------------------------------------------
   // Output stage: dox/doy/bo change only on iv and hold otherwise
   // ------------------------------------------------------------------
   logic [DW-1:0] dox_reg, doy_reg;
   logic          bo_reg, ov_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dox_reg <= '0;
         doy_reg <= '0;
         bo_reg  <= 1'b0;
         ov_reg  <= 1'b0;
      end else begin
         ov_reg <= iv;
         if (iv) begin
            dox_reg <= blank ? '0 : dlx_reg[DLY-1];
            doy_reg <= blank ? '0 : dly_reg[DLY-1];
            bo_reg  <= blank;
         end
      end
   end

   assign dox = dox_reg;
   assign doy = doy_reg;
   assign bo  = bo_reg;
   assign ov  = ov_reg;

   // ------------------------------------------------------------------
   // Peak magnitude (a clear wins over that cycle's sample)
   // ------------------------------------------------------------------
   logic [MW-1:0] peak_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         peak_reg <= '0;
      else if (pkrst)
         peak_reg <= '0;
      else if (iv && (mag > peak_reg))
         peak_reg <= mag;
   end

   assign peak = peak_reg;

   // ------------------------------------------------------------------
   // Pulse counter: counts window starts only, not retriggers
   // ------------------------------------------------------------------
`ifdef NB_PULSECNT_EN
   logic [15:0] pcnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pcnt_reg <= '0;
      else if (pkrst)
         pcnt_reg <= '0;
      else if (iv && det && !win_open && (pcnt_reg != 16'hFFFF))
         pcnt_reg <= pcnt_reg + 16'd1;
   end

   assign pcnt = pcnt_reg;
`else
   assign pcnt = 16'h0000;
`endif

endmodule
